// File: rtl/nanorv32_bus_arbiter_pkg.sv
// Shared state encodings and owner codes for the nanorv32 memory-port arbiter.
package nanorv32_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CODE = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam logic [1:0] OWNER_NONE = 2'd0;
  localparam logic [1:0] OWNER_CODE = 2'd1;
  localparam logic [1:0] OWNER_DATA = 2'd2;

  function automatic logic [1:0] owner_of(input arb_state_t state);
    case (state)
      ARB_CODE: return OWNER_CODE;
      ARB_DATA: return OWNER_DATA;
      default:  return OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/nanorv32_bus_arbiter_run_cnt.sv
// Saturating count of consecutive data grants taken while a fetch waits.
// Only present when NANORV32_ARB_FAIRNESS_EN is defined.
`ifdef NANORV32_ARB_FAIRNESS_EN
module nanorv32_arb_run_cnt #(
  parameter int MAX_RUN = 4,
  parameter int CNT_W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  logic [CNT_W-1:0] count;

  assign at_max = (count == CNT_W'(MAX_RUN));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/nanorv32_bus_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and load/store.
// Optional fetch-starvation limit enabled by NANORV32_ARB_FAIRNESS_EN.
import nanorv32_bus_arbiter_pkg::*;

module nanorv32_bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                codeif_req,
  input  logic [ADDR_W-1:0]   codeif_addr,
  output logic                codeif_gnt,
  output logic [DATA_W-1:0]   codeif_rdata,
  output logic                codeif_ready,

  input  logic                dataif_req,
  input  logic                dataif_we,
  input  logic [ADDR_W-1:0]   dataif_addr,
  input  logic [DATA_W-1:0]   dataif_wdata,
  input  logic [DATA_W/8-1:0] dataif_be,
  output logic                dataif_gnt,
  output logic [DATA_W-1:0]   dataif_rdata,
  output logic                dataif_ready,

  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,

  output logic [1:0]          arb_owner
);

  arb_state_t        state_q, state_d;
  logic              code_turn;
  logic              pick_code;
  logic [DATA_W-1:0] code_rdata_q, data_rdata_q;

`ifdef NANORV32_ARB_FAIRNESS_EN
  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);

  nanorv32_arb_run_cnt #(
    .MAX_RUN (MAX_DATA_RUN),
    .CNT_W   (RUN_W)
  ) u_run_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc    (dataif_gnt && codeif_req),
    .clr    (codeif_gnt),
    .at_max (code_turn)
  );
`else
  assign code_turn = 1'b0;
`endif

  // Data wins ties unless the fetch has been starved for a full run.
  assign pick_code = codeif_req && (!dataif_req || code_turn);

  always_comb begin
    state_d      = state_q;
    codeif_gnt   = 1'b0;
    dataif_gnt   = 1'b0;
    codeif_ready = 1'b0;
    dataif_ready = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (!rst) begin
          if (pick_code) begin
            codeif_gnt = 1'b1;
            state_d    = ARB_CODE;
          end else if (dataif_req) begin
            dataif_gnt = 1'b1;
            state_d    = ARB_DATA;
          end
        end
      end
      ARB_CODE: begin
        if (mem_ready) begin
          codeif_ready = !rst;
          state_d      = ARB_IDLE;
        end
      end
      ARB_DATA: begin
        if (mem_ready) begin
          dataif_ready = !rst;
          state_d      = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_be       <= '0;
      code_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (codeif_gnt) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= codeif_addr;
        mem_be   <= '1;
      end
      if (dataif_gnt) begin
        mem_req   <= 1'b1;
        mem_we    <= dataif_we;
        mem_addr  <= dataif_addr;
        mem_wdata <= dataif_wdata;
        mem_be    <= dataif_be;
      end
      if (codeif_ready) begin
        mem_req      <= 1'b0;
        code_rdata_q <= mem_rdata;
      end
      if (dataif_ready) begin
        mem_req      <= 1'b0;
        data_rdata_q <= mem_rdata;
      end
    end
  end

  // Completion-cycle bypass so the owner sees mem_rdata without a cycle of delay.
  assign codeif_rdata = codeif_ready ? mem_rdata : code_rdata_q;
  assign dataif_rdata = dataif_ready ? mem_rdata : data_rdata_q;
  assign arb_owner    = owner_of(state_q);

endmodule

// File: tb/tb_nanorv32_bus_arbiter.sv
// Directed, table-driven bench for nanorv32_bus_arbiter plus a grant-run sequence.
module tb_nanorv32_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        codeif_req;
  logic [31:0] codeif_addr;
  logic        codeif_gnt;
  logic [31:0] codeif_rdata;
  logic        codeif_ready;
  logic        dataif_req;
  logic        dataif_we;
  logic [31:0] dataif_addr;
  logic [31:0] dataif_wdata;
  logic [3:0]  dataif_be;
  logic        dataif_gnt;
  logic [31:0] dataif_rdata;
  logic        dataif_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [1:0]  arb_owner;

`ifdef NANORV32_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  int assertions = 0;
  int failures   = 0;

  nanorv32_bus_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MAX_DATA_RUN (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .codeif_req   (codeif_req),
    .codeif_addr  (codeif_addr),
    .codeif_gnt   (codeif_gnt),
    .codeif_rdata (codeif_rdata),
    .codeif_ready (codeif_ready),
    .dataif_req   (dataif_req),
    .dataif_we    (dataif_we),
    .dataif_addr  (dataif_addr),
    .dataif_wdata (dataif_wdata),
    .dataif_be    (dataif_be),
    .dataif_gnt   (dataif_gnt),
    .dataif_rdata (dataif_rdata),
    .dataif_ready (dataif_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .arb_owner    (arb_owner)
  );

  always #5 clk = ~clk;

  // One cycle: inputs, then the outputs expected right after applying them.
  typedef struct {
    logic [31:0] rst, creq, caddr, dreq, dwe, daddr, dwdata, dbe, mrdy, mrdata;
    logic [31:0] cgnt, dgnt, crdy, drdy, crdata, drdata;
    logic [31:0] mreq, mwe, maddr, mwdata, mbe, owner;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  task automatic applyStimulus(input vec_t v);
    rst          = v.rst[0];
    codeif_req   = v.creq[0];
    codeif_addr  = v.caddr;
    dataif_req   = v.dreq[0];
    dataif_we    = v.dwe[0];
    dataif_addr  = v.daddr;
    dataif_wdata = v.dwdata;
    dataif_be    = v.dbe[3:0];
    mem_ready    = v.mrdy[0];
    mem_rdata    = v.mrdata;
  endtask

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s[%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  initial begin
    int grants;
    int last_cycle;
    logic exp_code;

    //            rst creq caddr    dreq dwe daddr   dwdata        dbe   mrdy mrdata
    //            cg dg cr dr crdata drdata        mreq mwe maddr   mwdata        mbe   own
    vecs[0]  = '{1, 0, 0,       0, 0, 0,      0,            0,    0, 0,
                 0, 0, 0, 0, 0,     0,             0, 0, 0,      0,            0,    0};
    vecs[1]  = '{0, 1, 'h100,   0, 0, 0,      0,            0,    0, 0,
                 1, 0, 0, 0, 0,     0,             0, 0, 0,      0,            0,    0};
    vecs[2]  = '{0, 1, 'h100,   0, 0, 0,      0,            0,    1, 'h13,
                 0, 0, 1, 0, 'h13,  0,             1, 0, 'h100,  0,            'hF,  1};
    vecs[3]  = '{0, 0, 0,       0, 0, 0,      0,            0,    1, 'h55,
                 0, 0, 0, 0, 'h13,  0,             0, 0, 'h100,  0,            'hF,  0};
    vecs[4]  = '{0, 1, 'h104,   1, 1, 'h200,  'hDEADBEEF,   'hF,  0, 0,
                 0, 1, 0, 0, 'h13,  0,             0, 0, 'h100,  0,            'hF,  0};
    vecs[5]  = '{0, 1, 'h104,   1, 1, 'h200,  'hDEADBEEF,   'hF,  0, 0,
                 0, 0, 0, 0, 'h13,  0,             1, 1, 'h200,  'hDEADBEEF,   'hF,  2};
    vecs[6]  = '{0, 1, 'h104,   1, 1, 'h200,  'hDEADBEEF,   'hF,  1, 'h77,
                 0, 0, 0, 1, 'h13,  'h77,          1, 1, 'h200,  'hDEADBEEF,   'hF,  2};
    vecs[7]  = '{0, 1, 'h104,   0, 0, 0,      0,            0,    0, 0,
                 1, 0, 0, 0, 'h13,  'h77,          0, 1, 'h200,  'hDEADBEEF,   'hF,  0};
    vecs[8]  = '{0, 1, 'h104,   0, 0, 0,      0,            0,    1, 'hAA,
                 0, 0, 1, 0, 'hAA,  'h77,          1, 0, 'h104,  'hDEADBEEF,   'hF,  1};
    vecs[9]  = '{0, 0, 0,       1, 0, 'h300,  0,            'h3,  0, 0,
                 0, 1, 0, 0, 'hAA,  'h77,          0, 0, 'h104,  'hDEADBEEF,   'hF,  0};
    vecs[10] = '{0, 0, 0,       1, 0, 'h300,  0,            'h3,  0, 'hBAD,
                 0, 0, 0, 0, 'hAA,  'h77,          1, 0, 'h300,  0,            'h3,  2};
    vecs[11] = vecs[10];
    vecs[12] = vecs[10];
    vecs[13] = '{0, 0, 0,       1, 0, 'h300,  0,            'h3,  1, 'h12345678,
                 0, 0, 0, 1, 'hAA,  'h12345678,    1, 0, 'h300,  0,            'h3,  2};
    vecs[14] = '{0, 0, 0,       0, 0, 0,      0,            0,    0, 0,
                 0, 0, 0, 0, 'hAA,  'h12345678,    0, 0, 'h300,  0,            'h3,  0};
    vecs[15] = '{0, 0, 0,       1, 1, 'h400,  'h0BADF00D,   'hC,  0, 0,
                 0, 1, 0, 0, 'hAA,  'h12345678,    0, 0, 'h300,  0,            'h3,  0};
    vecs[16] = '{1, 0, 0,       1, 1, 'h400,  'h0BADF00D,   'hC,  0, 0,
                 0, 0, 0, 0, 'hAA,  'h12345678,    1, 1, 'h400,  'h0BADF00D,   'hC,  2};
    vecs[17] = '{0, 0, 0,       0, 0, 0,      0,            0,    1, 'h99,
                 0, 0, 0, 0, 0,     0,             0, 0, 0,      0,            0,    0};

    rst = 1'b1; codeif_req = 1'b0; codeif_addr = '0; dataif_req = 1'b0; dataif_we = 1'b0;
    dataif_addr = '0; dataif_wdata = '0; dataif_be = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput("codeif_gnt",   i, 32'(codeif_gnt),   vecs[i].cgnt);
      checkOutput("dataif_gnt",   i, 32'(dataif_gnt),   vecs[i].dgnt);
      checkOutput("codeif_ready", i, 32'(codeif_ready), vecs[i].crdy);
      checkOutput("dataif_ready", i, 32'(dataif_ready), vecs[i].drdy);
      checkOutput("codeif_rdata", i, codeif_rdata,      vecs[i].crdata);
      checkOutput("dataif_rdata", i, dataif_rdata,      vecs[i].drdata);
      checkOutput("mem_req",      i, 32'(mem_req),      vecs[i].mreq);
      checkOutput("mem_we",       i, 32'(mem_we),       vecs[i].mwe);
      checkOutput("mem_addr",     i, mem_addr,          vecs[i].maddr);
      checkOutput("mem_wdata",    i, mem_wdata,         vecs[i].mwdata);
      checkOutput("mem_be",       i, 32'(mem_be),       vecs[i].mbe);
      checkOutput("arb_owner",    i, 32'(arb_owner),    vecs[i].owner);
    end

    // Both requesters held with a zero-wait memory: grants every other cycle,
    // and with the run limit every fifth grant goes to the fetch side.
    @(negedge clk);
    rst = 1'b0; codeif_req = 1'b1; codeif_addr = 32'h500;
    dataif_req = 1'b1; dataif_we = 1'b0; dataif_addr = 32'h600; dataif_be = 4'hF;
    mem_ready = 1'b1; mem_rdata = 32'h0;
    grants = 0;
    last_cycle = -1;
    for (int c = 0; c < 40 && grants < 10; c++) begin
      #1;
      if (codeif_gnt || dataif_gnt) begin
        exp_code = FAIR && (grants % 5 == 4);
        checkOutput("run_codeif_gnt", grants, 32'(codeif_gnt), 32'(exp_code));
        checkOutput("run_dataif_gnt", grants, 32'(dataif_gnt), 32'(!exp_code));
        grants++;
        last_cycle = c;
      end
      @(negedge clk);
    end
    checkOutput("run_grant_count", 0, 32'(grants), 32'd10);
    checkOutput("run_last_grant_cycle", 0, 32'(last_cycle), 32'd18);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
